// File: rtl/readout_pkg.sv
// Shared definitions for the result readout sequencer.
// Holds the sequencer state encoding, the default frame header byte and the
// frame shape constants (bytes per payload word, header and trailer length).
package readout_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_WAIT,
    S_SEND_HI,
    S_SEND_LO,
    S_CHK,
    S_DONE
  } readout_state_t;

  localparam logic [7:0] SOF_BYTE_DEFAULT = 8'hA5;
  localparam int         BYTES_PER_WORD   = 2;
  localparam int         HDR_LEN          = 1;
  localparam int         TRL_LEN          = 1;

endpackage

// File: rtl/result_readout_sequencer_if.sv
// Bus bundle between the sequencer and its neighbours.
//   mem_addr / mem_q : parallel read port of the result memory
//   tx_data / tx_valid / tx_ready : byte stream towards the GPIO link
// Handshake: a byte transfers on a rising edge where tx_valid and tx_ready
// are both high. While tx_valid is high and tx_ready low, tx_data and
// tx_valid hold; tx_valid only drops after a transfer (or on reset).
// master = sequencer side, slave = memory/link side.
interface result_readout_sequencer_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_q;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output mem_addr, tx_data, tx_valid,
    input  mem_q, tx_ready
  );

  modport slave (
    input  mem_addr, tx_data, tx_valid,
    output mem_q, tx_ready
  );
endinterface

// File: rtl/readout_byte_tx.sv
// Output holding register for the framed byte stream.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   load       : capture load_data and raise tx_valid (only asserted by the
//                sequencer when the register is empty or is transferring)
//   load_data  : next byte
//   tx_data    : registered byte, tx_valid : registered valid
//   tx_ready   : link ready
//   fire       : transfer happens at the coming edge (tx_valid & tx_ready)
module readout_byte_tx (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_data,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       fire
);

  assign fire = tx_valid & tx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
    end else if (load) begin
      tx_data  <= load_data;
      tx_valid <= 1'b1;
    end else if (fire) begin
      // Byte taken with nothing queued behind it; data keeps its last value.
      tx_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/result_readout_sequencer.sv
// Walks a window of the result memory and sends it to the host as a frame:
// SOF header, each 16-bit word MSB byte first, then the XOR of all payload
// bytes.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : frame request, only looked at in IDLE
//   base_addr  : first word address, count : number of words (both captured
//                on an accepted start)
//   bus        : memory read port + byte stream (master side)
//   busy       : frame in progress (cycle after start until DONE)
//   done       : one-cycle end-of-frame pulse
//   state      : current sequencer state, for observation
module result_readout_sequencer
  import readout_pkg::*;
#(
  parameter int         ADDR_W   = 24,
  parameter int         DATA_W   = 16,
  parameter int         RD_LAT   = 1,
  parameter logic [7:0] SOF_BYTE = SOF_BYTE_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          base_addr,
  input  logic [15:0]                count,
  result_readout_sequencer_if.master bus,
  output logic                       busy,
  output logic                       done,
  output readout_state_t             state
);

  localparam int WORD_W = 8 * BYTES_PER_WORD;
  localparam int WAIT_W = $clog2(RD_LAT + 2);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LAT);

  logic [ADDR_W-1:0] addr;
  logic [15:0]       remaining;
  logic [WORD_W-1:0] word;
  logic [7:0]        chk;
  logic [WAIT_W-1:0] wait_cnt;

  logic              load;
  logic [7:0]        load_data;
  logic              fire;

  // Next byte for the holding register. A byte is loaded on the edge that
  // enters each sending state, so tx_valid is already high in that state.
  // On the word load the register takes mem_q directly because word is being
  // captured on the same edge; likewise the checksum byte includes the low
  // byte being transferred on the same edge.
  always_comb begin
    load      = 1'b0;
    load_data = 8'h00;
    case (state)
      S_IDLE: if (start) begin
        load      = 1'b1;
        load_data = SOF_BYTE;
      end
      S_HDR: if (fire && remaining == 16'd0) begin
        load      = 1'b1;
        load_data = chk;
      end
      S_WAIT: if (wait_cnt == WAIT_LAST) begin
        load      = 1'b1;
        load_data = bus.mem_q[15:8];
      end
      S_SEND_HI: if (fire) begin
        load      = 1'b1;
        load_data = word[7:0];
      end
      S_SEND_LO: if (fire && remaining == 16'd1) begin
        load      = 1'b1;
        load_data = chk ^ word[7:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      addr         <= '0;
      bus.mem_addr <= '0;
      remaining    <= 16'd0;
      word         <= '0;
      chk          <= 8'h00;
      wait_cnt     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          addr      <= base_addr;
          remaining <= count;
          chk       <= 8'h00;
          busy      <= 1'b1;
          state     <= S_HDR;
        end
        S_HDR: if (fire) begin
          if (remaining != 16'd0) begin
            bus.mem_addr <= addr;
            wait_cnt     <= '0;
            state        <= S_WAIT;
          end else begin
            state <= S_CHK;
          end
        end
        S_WAIT: begin
          // mem_addr was set on entry; give the memory RD_LAT edges, then
          // sample on the last WAIT cycle.
          if (wait_cnt == WAIT_LAST) begin
            word  <= bus.mem_q;
            state <= S_SEND_HI;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_SEND_HI: if (fire) begin
          chk   <= chk ^ word[15:8];
          state <= S_SEND_LO;
        end
        S_SEND_LO: if (fire) begin
          chk <= chk ^ word[7:0];
          if (remaining == 16'd1) begin
            state <= S_CHK;
          end else begin
            addr         <= addr + ADDR_W'(1);
            bus.mem_addr <= addr + ADDR_W'(1);
            remaining    <= remaining - 16'd1;
            wait_cnt     <= '0;
            state        <= S_WAIT;
          end
        end
        S_CHK: if (fire) begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  readout_byte_tx u_byte_tx (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (load_data),
    .tx_data   (bus.tx_data),
    .tx_valid  (bus.tx_valid),
    .tx_ready  (bus.tx_ready),
    .fire      (fire)
  );

endmodule

// File: tb/tb_result_readout_sequencer.sv
// Bench for result_readout_sequencer: synchronous RAM model, ready driver,
// expected-byte queue checked by a monitor, final report.
module tb_result_readout_sequencer;
  import readout_pkg::*;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [15:0]       count = 16'd0;
  logic              busy, done;
  readout_state_t    dut_state;

  result_readout_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  result_readout_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1), .SOF_BYTE(8'hA5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .bus       (bus.master),
    .busy      (busy),
    .done      (done),
    .state     (dut_state)
  );

  // ---------------- memory model (1-cycle synchronous read) ----------------
  logic [15:0] mem [logic [ADDR_W-1:0]];

  function automatic logic [15:0] rd_mem(input logic [ADDR_W-1:0] a);
    if (mem.exists(a)) return mem[a];
    return 16'h0000;
  endfunction

  always @(posedge clk) bus.mem_q <= rd_mem(bus.mem_addr);

  // ---------------- tx_ready driver ----------------
  logic rand_ready = 1'b0;
  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.tx_ready = rand_ready ? ($urandom_range(0, 99) < 40) : 1'b1;
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int hs_cnt   = 0;
  int done_cnt = 0;
  logic [7:0]        exp_q[$];
  logic [7:0]        vec[$];
  logic [ADDR_W-1:0] wait_addrs[$];
  logic [ADDR_W-1:0] avec[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Byte monitor: every transfer pops one expected byte.
  always @(negedge clk) begin
    logic [7:0] exp_b;
    if (!rst && bus.tx_valid && bus.tx_ready) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_byte: got %h expected none", bus.tx_data);
      end else begin
        exp_b = exp_q.pop_front();
        check("tx_byte", 32'(bus.tx_data), 32'(exp_b));
      end
    end
  end

  // Backpressure hold monitor.
  logic       prev_rst = 1'b1, prev_valid = 1'b0, prev_ready = 1'b0;
  logic [7:0] prev_data = 8'h00;
  always @(negedge clk) begin
    if (!prev_rst && prev_valid && !prev_ready) begin
      check("hold_valid", 32'(bus.tx_valid), 32'd1);
      check("hold_data", 32'(bus.tx_data), 32'(prev_data));
    end
    prev_rst   = rst;
    prev_valid = bus.tx_valid;
    prev_ready = bus.tx_ready;
    prev_data  = bus.tx_data;
  end

  // Record distinct addresses presented during WAIT, and count done pulses.
  always @(negedge clk) begin
    if (!rst && dut_state == S_WAIT)
      if (wait_addrs.size() == 0 || wait_addrs[$] != bus.mem_addr)
        wait_addrs.push_back(bus.mem_addr);
    if (done) done_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic expect_vec();
    foreach (vec[i]) exp_q.push_back(vec[i]);
  endtask

  task automatic start_frame(input logic [ADDR_W-1:0] b, input logic [15:0] c);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; count = c;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts cycles from the one after start acceptance up to the done cycle.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (cycles < 3000) begin
      @(negedge clk);
      cycles++;
      if (done) break;
    end
    check("frame_done", 32'(done), 32'd1);
  endtask

  task automatic check_addrs(input string name);
    check(name, 32'(wait_addrs.size()), 32'(avec.size()));
    foreach (avec[i])
      if (i < wait_addrs.size()) check(name, 32'(wait_addrs[i]), 32'(avec[i]));
  endtask

  task automatic frame_tail(input string name, input int d0);
    repeat (3) @(negedge clk);
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({name, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    check({name, "_idle"}, 32'(dut_state), 32'(S_IDLE));
  endtask

  // ---------------- tests ----------------
  initial begin
    int cyc, d0, h0;
    logic [ADDR_W-1:0] a0;

    mem[24'd4] = 16'd5;  mem[24'd5] = 16'd7;  mem[24'd6] = 16'd13;
    mem[24'd7] = 16'd19; mem[24'd8] = 16'd23; mem[24'd9] = 16'd24;
    mem[24'd124] = 16'd2000;
    mem[24'hFFFFFF] = 16'h1234;
    mem[24'h000000] = 16'hABCD;
    mem[24'd100] = 16'hFFFF;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_state", 32'(dut_state), 32'(S_IDLE));

    // Six words, ready always high, stray start mid-frame.
    vec = '{8'hA5, 8'h00, 8'h05, 8'h00, 8'h07, 8'h00, 8'h0D,
            8'h00, 8'h13, 8'h00, 8'h17, 8'h00, 8'h18, 8'h13};
    expect_vec();
    wait_addrs.delete();
    d0 = done_cnt;
    start_frame(24'd4, 16'd6);
    check("busy_after_start", 32'(busy), 32'd1);
    fork
      wait_done(cyc);
      begin
        repeat (5) @(posedge clk);
        #1 start = 1'b1; base_addr = 24'd100; count = 16'd3;
        @(posedge clk); #1 start = 1'b0;
      end
    join
    check("six_cycles", 32'(cyc), 32'(HDR_LEN + 4 * 6 + TRL_LEN + 1));
    check("six_busy_at_done", 32'(busy), 32'd0);
    avec = '{24'd4, 24'd5, 24'd6, 24'd7, 24'd8, 24'd9};
    check_addrs("six_addrs");
    frame_tail("six", d0);

    // Single word at 124.
    vec = '{8'hA5, 8'h07, 8'hD0, 8'hD7};
    expect_vec();
    wait_addrs.delete();
    d0 = done_cnt;
    start_frame(24'd124, 16'd1);
    wait_done(cyc);
    check("one_cycles", 32'(cyc), 32'd7);
    avec = '{24'd124};
    check_addrs("one_addrs");
    frame_tail("one", d0);

    // Six words with random backpressure.
    rand_ready = 1'b1;
    vec = '{8'hA5, 8'h00, 8'h05, 8'h00, 8'h07, 8'h00, 8'h0D,
            8'h00, 8'h13, 8'h00, 8'h17, 8'h00, 8'h18, 8'h13};
    expect_vec();
    wait_addrs.delete();
    d0 = done_cnt;
    start_frame(24'd4, 16'd6);
    wait_done(cyc);
    rand_ready = 1'b0;
    avec = '{24'd4, 24'd5, 24'd6, 24'd7, 24'd8, 24'd9};
    check_addrs("bp_addrs");
    frame_tail("bp", d0);

    // Empty frame.
    a0 = bus.mem_addr;
    vec = '{8'hA5, 8'h00};
    expect_vec();
    wait_addrs.delete();
    d0 = done_cnt;
    start_frame(24'd50, 16'd0);
    wait_done(cyc);
    check("zero_cycles", 32'(cyc), 32'd3);
    check("zero_mem_addr", 32'(bus.mem_addr), 32'(a0));
    check("zero_no_wait", 32'(wait_addrs.size()), 32'd0);
    frame_tail("zero", d0);

    // Address wrap.
    vec = '{8'hA5, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    expect_vec();
    wait_addrs.delete();
    d0 = done_cnt;
    start_frame(24'hFFFFFF, 16'd2);
    wait_done(cyc);
    avec = '{24'hFFFFFF, 24'h000000};
    check_addrs("wrap_addrs");
    frame_tail("wrap", d0);

    // Reset after the third transferred byte, then a fresh frame.
    vec = '{8'hA5, 8'h00, 8'h05};
    expect_vec();
    d0 = done_cnt;
    h0 = hs_cnt;
    start_frame(24'd4, 16'd6);
    for (int k = 0; k < 100 && hs_cnt < h0 + 3; k++) @(negedge clk);
    check("abort_bytes_seen", 32'(hs_cnt - h0), 32'd3);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("abort_state", 32'(dut_state), 32'(S_IDLE));
    repeat (10) @(negedge clk);
    check("abort_no_resume", 32'(hs_cnt - h0), 32'd3);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);

    vec = '{8'hA5, 8'h00, 8'h05, 8'h00, 8'h07, 8'h00, 8'h0D,
            8'h00, 8'h13, 8'h00, 8'h17, 8'h00, 8'h18, 8'h13};
    expect_vec();
    wait_addrs.delete();
    d0 = done_cnt;
    start_frame(24'd4, 16'd6);
    wait_done(cyc);
    check("fresh_cycles", 32'(cyc), 32'd27);
    avec = '{24'd4, 24'd5, 24'd6, 24'd7, 24'd8, 24'd9};
    check_addrs("fresh_addrs");
    frame_tail("fresh", d0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/result_readout_sequencer.md
Name: result_readout_sequencer

Overview:
- Sits downstream of the processor's parallel result-memory read port.
- On a start request it walks the memory address across a window of results: it drives the address bus and samples the 16-bit read data.
- It serialises each word into a framed byte stream (header, payload MSB-first, XOR checksum) on a valid/ready byte interface feeding the GPIO link to the host.
- It replaces the manual address stepping currently done by hand or by bench.

Parameters:
ADDR_W, 24, width of memory address (matches parallel address bus)
DATA_W, 16, width of memory read data; must be 16 (two bytes per word)
RD_LAT, 1, clock edges from address change until mem_q is valid (synchronous RAM = 1)
SOF_BYTE, 8'hA5, frame header byte

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request a frame; sampled only in IDLE
base_addr  in  ADDR_W  first word address, captured on accepted start
count  in  16  number of words to send, captured on accepted start
mem_addr  out  ADDR_W  address to result memory (parallel address input)
mem_q  in  DATA_W  read data from result memory
tx_data  out  8  byte to GPIO link
tx_valid  out  1  tx_data valid
tx_ready  in  1  link accepts byte when tx_valid and tx_ready are both high at a rising edge
busy  out  1  high from the cycle after start acceptance until the DONE state
done  out  1  single-cycle pulse at end of frame

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state IDLE; mem_addr=0; tx_data=0; tx_valid=0; busy=0; done=0; internal addr, remaining, word and checksum registers = 0.
- rst has priority over all other inputs, including mid-frame. The next cycle shows the reset values; a partial frame is abandoned and never resumed.
- States: IDLE, HDR, WAIT, SEND_HI, SEND_LO, CHK, DONE. All outputs are registered or Moore-decoded from state.
- IDLE, start=1: addr<=base_addr, remaining<=count, chk<=0, go to HDR.
- HDR: tx_valid=1, tx_data=SOF_BYTE. On handshake: go to WAIT if remaining!=0, else CHK.
- WAIT: mem_addr=addr, held stable. Lasts RD_LAT+1 cycles (wait counter). On the last cycle, word<=mem_q, then go to SEND_HI.
- SEND_HI: tx_data=word[15:8]. On handshake: chk^=word[15:8], go to SEND_LO.
- SEND_LO: tx_data=word[7:0]. On handshake: chk^=word[7:0]. If remaining==1, go to CHK. Otherwise addr<=addr+1 (wraps modulo 2^ADDR_W), remaining-=1, go to WAIT.
- CHK: tx_data=chk, the XOR of all payload bytes; the header is excluded. On handshake, go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- Handshake rule: while tx_valid=1 and tx_ready=0, tx_data and tx_valid are held unchanged. tx_valid never drops without a handshake, except on rst.
- Throughput with tx_ready held at 1 and RD_LAT=1: 4 cycles per word. Frame length in cycles = 1 (HDR) + 4*count + 1 (CHK) + 1 (DONE).
- start while busy is ignored; it is neither queued nor allowed to change the captured base_addr or count.
- count=0 produces the frame A5, 00 followed by done.
- mem_addr updates only on WAIT entry; it holds its last value in HDR, SEND and CHK states and through IDLE.

Decomposition:
- Shared package readout_pkg holds:
  - state enum readout_state_t;
  - SOF_BYTE default;
  - frame constants (bytes per word = 2, header/trailer length).
- One sub-module is natural: readout_byte_tx, an 8-bit output holding register with the valid/ready handshake and hold-under-backpressure logic.
- The sequencer FSM, address counter and checksum stay in the top module.

Test Plan:
- Memory model with [4..9]={5,7,13,19,23,24}. Drive base=4, count=6, tx_ready=1 -> bytes A5,00,05,00,07,00,0D,00,13,00,17,00,18,13. Also require one done pulse, and 27 cycles from start acceptance to done.
- Memory model with [124]=2000. Drive base=124, count=1 -> bytes A5,07,D0,D7. mem_addr=124 throughout WAIT.
- Repeat the first case with tx_ready pseudo-random at about 40% -> identical byte stream. tx_data and tx_valid are stable on every cycle where valid=1 and ready=0.
- Drive count=0 -> bytes A5,00, then done. mem_addr does not change.
- Drive base=24'hFFFFFF, count=2 -> mem_addr shows FFFFFF, then 000000. Payload equals memory at those two addresses.
- Assert rst after the 3rd accepted byte -> next cycle tx_valid=0, busy=0, mem_addr=0. A start pulse while busy (earlier run) has no effect. A fresh start after reset yields a complete, correct frame.
